// File: rtl/pitch_tracker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : Axis_If                                                         |
// | Brief    : valid/ready/data stream bundle shared by pitch_tracker ports    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface Axis_If #(
   parameter int DWIDTH = 24
) ();
   logic              valid;
   logic              ready;
   logic [DWIDTH-1:0] data;

   modport Master (output valid, output data, input ready);
   modport Slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/pitch_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pitch_tracker                                                   |
// | Brief    : range/outlier rejection, lock hysteresis and moving average of  |
// |            raw 14.10 Hz pitch estimates. Optional PITCH_TRACKER_OCTAVE_FIX_EN|
// |            folds octave errors back onto the tracked pitch.                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pitch_tracker #(
   parameter logic [23:0] F_MIN      = 24'h00C800,
   parameter logic [23:0] F_MAX      = 24'h1F4000,
   parameter int          DEV_SHIFT  = 4,
   parameter int          ACQ_COUNT  = 3,
   parameter int          HOLD_COUNT = 4,
   parameter int          AVG_LOG2   = 3
) (
   input  logic   clk,
   input  logic   reset,
   Axis_If.Slave  pitch_in,
   Axis_If.Master pitch_out,
   output logic   voiced
);

   localparam int c_taps  = 1 << AVG_LOG2;
   localparam int c_sum_w = 24 + AVG_LOG2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACQUIRE = 2'd1,
      S_TRACK   = 2'd2
   } state_t;

   state_t               r_state, w_state_nxt;
   logic                 r_in_valid, r_out_valid, r_voiced;
   logic [23:0]          r_in_data, r_out_data, r_cand;
   logic [7:0]           r_acq, r_miss;
   logic [c_sum_w-1:0]   r_sum;
   logic [23:0]          r_win [c_taps];
   logic [AVG_LOG2-1:0]  r_idx;

   logic                 w_in_ready, w_in_range, w_trk_hit;
   logic [23:0]          w_avg, w_trk_val, w_cand_nxt, w_out_data;
   logic [7:0]           w_acq_nxt, w_miss_nxt;
   logic [c_sum_w-1:0]   w_sum_nxt;
   logic                 w_out_voiced, w_fill, w_clear, w_push;

   function automatic logic f_hit(input logic [23:0] p, input logic [23:0] ref_v);
      logic [23:0] mag;
      mag = (p >= ref_v) ? (p - ref_v) : (ref_v - p);
      return (p >= F_MIN) && (p <= F_MAX) && (mag <= (ref_v >> DEV_SHIFT));
   endfunction

   assign w_in_ready      = !r_in_valid && !r_out_valid;
   assign pitch_in.ready  = w_in_ready;
   assign pitch_out.valid = r_out_valid;
   assign pitch_out.data  = r_out_data;
   assign voiced          = r_voiced;
   assign w_in_range      = (r_in_data >= F_MIN) && (r_in_data <= F_MAX);
   assign w_avg           = r_sum[c_sum_w-1:AVG_LOG2];

`ifdef PITCH_TRACKER_OCTAVE_FIX_EN
   logic [24:0] w_dbl;
`endif

   always_comb begin
      w_trk_hit = f_hit(r_in_data, w_avg);
      w_trk_val = r_in_data;
`ifdef PITCH_TRACKER_OCTAVE_FIX_EN
      w_dbl = {r_in_data, 1'b0};
      if (!w_trk_hit) begin
         if (f_hit(r_in_data >> 1, w_avg)) begin
            w_trk_hit = 1'b1;
            w_trk_val = r_in_data >> 1;
         end else if (!w_dbl[24] && f_hit(w_dbl[23:0], w_avg)) begin
            w_trk_hit = 1'b1;
            w_trk_val = w_dbl[23:0];
         end
      end
`endif
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cand_nxt   = r_cand;
      w_acq_nxt    = r_acq;
      w_miss_nxt   = r_miss;
      w_sum_nxt    = r_sum;
      w_out_data   = '0;
      w_out_voiced = 1'b0;
      w_fill       = 1'b0;
      w_clear      = 1'b0;
      w_push       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_in_range) begin
               w_cand_nxt = r_in_data;
               w_acq_nxt  = 8'd1;
               if (ACQ_COUNT <= 1) begin
                  w_state_nxt  = S_TRACK;
                  w_fill       = 1'b1;
                  w_sum_nxt    = {r_in_data, {AVG_LOG2{1'b0}}};
                  w_miss_nxt   = '0;
                  w_out_data   = r_in_data;
                  w_out_voiced = 1'b1;
               end else begin
                  w_state_nxt = S_ACQUIRE;
               end
            end
         end
         S_ACQUIRE: begin
            if (f_hit(r_in_data, r_cand)) begin
               w_cand_nxt = r_in_data;
               w_acq_nxt  = r_acq + 8'd1;
               if ((r_acq + 8'd1) >= 8'(ACQ_COUNT)) begin
                  w_state_nxt  = S_TRACK;
                  w_fill       = 1'b1;
                  w_sum_nxt    = {r_in_data, {AVG_LOG2{1'b0}}};
                  w_miss_nxt   = '0;
                  w_out_data   = r_in_data;
                  w_out_voiced = 1'b1;
               end
            end else if (w_in_range) begin
               w_cand_nxt = r_in_data;
               w_acq_nxt  = 8'd1;
            end else begin
               w_state_nxt = S_IDLE;
               w_acq_nxt   = '0;
            end
         end
         S_TRACK: begin
            if (w_trk_hit) begin
               w_push       = 1'b1;
               w_sum_nxt    = r_sum + {{AVG_LOG2{1'b0}}, w_trk_val}
                                    - {{AVG_LOG2{1'b0}}, r_win[r_idx]};
               w_miss_nxt   = '0;
               w_out_data   = w_sum_nxt[c_sum_w-1:AVG_LOG2];
               w_out_voiced = 1'b1;
            end else if ((r_miss + 8'd1) >= 8'(HOLD_COUNT)) begin
               w_state_nxt = S_IDLE;
               w_clear     = 1'b1;
               w_sum_nxt   = '0;
               w_miss_nxt  = '0;
               w_acq_nxt   = '0;
            end else begin
               w_miss_nxt   = r_miss + 8'd1;
               w_out_data   = w_avg;
               w_out_voiced = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else if (r_in_valid)
         r_state <= w_state_nxt;
   end

   // One beat in flight at a time: the output register must drain before the next accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_valid  <= 1'b0;
         r_in_data   <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_voiced    <= 1'b0;
         r_cand      <= '0;
         r_acq       <= '0;
         r_miss      <= '0;
         r_sum       <= '0;
      end else begin
         if (r_out_valid && pitch_out.ready)
            r_out_valid <= 1'b0;
         if (r_in_valid) begin
            r_in_valid  <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_data;
            r_voiced    <= w_out_voiced;
            r_cand      <= w_cand_nxt;
            r_acq       <= w_acq_nxt;
            r_miss      <= w_miss_nxt;
            r_sum       <= w_sum_nxt;
         end else if (pitch_in.valid && w_in_ready) begin
            r_in_valid <= 1'b1;
            r_in_data  <= pitch_in.data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < c_taps; i++)
            r_win[i] <= '0;
         r_idx <= '0;
      end else if (r_in_valid) begin
         if (w_fill || w_clear) begin
            for (int i = 0; i < c_taps; i++)
               r_win[i] <= w_fill ? r_in_data : 24'd0;
            r_idx <= '0;
         end else if (w_push) begin
            r_win[r_idx] <= w_trk_val;
            r_idx        <= r_idx + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pitch_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pitch_tracker                                                |
// | Brief    : random + directed scoreboard bench for pitch_tracker            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pitch_tracker;
   localparam int FMIN = 32'h00C800;
   localparam int FMAX = 32'h1F4000;
   localparam int ACQ  = 3;
   localparam int HOLD = 4;
   localparam int L    = 3;

   logic clk = 1'b0;
   logic reset;
   logic voiced;
   Axis_If #(.DWIDTH(24)) in_if ();
   Axis_If #(.DWIDTH(24)) out_if ();

   pitch_tracker dut (
      .clk       (clk),
      .reset     (reset),
      .pitch_in  (in_if),
      .pitch_out (out_if),
      .voiced    (voiced)
   );

   always #5 clk = ~clk;

   typedef struct { int data; bit v; } exp_t;
   exp_t exp_q[$];
   int   acc_q[$];
   int   total = 0, bad = 0, cyc = 0;
   bit   hold_bp = 1'b0;

   // behavioural reference: 0=idle 1=acquiring 2=tracking
   int mode, cand, acq, miss;
   int win[$];

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @cyc %0d", name, act, req, cyc);
      end
   endtask

   function automatic bit m_hit(input int p, input int r);
      int d;
      d = (p > r) ? p - r : r - p;
      return (p >= FMIN) && (p <= FMAX) && (d <= (r >> 4));
   endfunction

   function automatic int m_avg();
      int s = 0;
      foreach (win[i]) s += win[i];
      return s / (1 << L);
   endfunction

   task automatic m_reset();
      mode = 0; cand = 0; acq = 0; miss = 0;
      win.delete();
   endtask

   task automatic m_lock(input int p, output int od, output bit ov);
      win.delete();
      for (int i = 0; i < (1 << L); i++) win.push_back(p);
      mode = 2; miss = 0; od = p; ov = 1'b1;
   endtask

   task automatic m_step(input int p, output int od, output bit ov);
      bit inr, h;
      int a, v;
      inr = (p >= FMIN) && (p <= FMAX);
      od = 0; ov = 1'b0;
      if (mode == 0) begin
         if (inr) begin
            cand = p; acq = 1;
            if (ACQ == 1) m_lock(p, od, ov); else mode = 1;
         end
      end else if (mode == 1) begin
         if (m_hit(p, cand)) begin
            acq++; cand = p;
            if (acq >= ACQ) m_lock(p, od, ov);
         end else if (inr) begin
            cand = p; acq = 1;
         end else begin
            mode = 0; acq = 0;
         end
      end else begin
         a = m_avg();
         v = p;
         h = m_hit(p, a);
`ifdef PITCH_TRACKER_OCTAVE_FIX_EN
         if (!h && m_hit(p / 2, a)) begin h = 1; v = p / 2; end
         else if (!h && m_hit(p * 2, a)) begin h = 1; v = p * 2; end
`endif
         if (h) begin
            void'(win.pop_front());
            win.push_back(v);
            miss = 0; od = m_avg(); ov = 1'b1;
         end else begin
            miss++;
            if (miss >= HOLD) begin
               mode = 0; miss = 0; acq = 0;
               win.delete();
            end else begin
               od = a; ov = 1'b1;
            end
         end
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      out_if.ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_if.ready = hold_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // monitor: pops the scoreboard on each output handshake, checks stalls and latency
   initial begin
      bit          prev_stall = 0, prev_valid = 0, prev_v = 0;
      logic [23:0] prev_data = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 0; prev_valid = 0;
            continue;
         end
         if (out_if.valid) begin
            chk("in_ready_while_out_valid", int'(in_if.ready), 0);
            if (!prev_valid) begin
               if (acc_q.size() == 0) chk("unexpected_output", 1, 0);
               else chk("latency", cyc - acc_q.pop_front(), 2);
            end
            if (prev_stall) begin
               chk("stall_data", int'(out_if.data), int'(prev_data));
               chk("stall_voiced", int'(voiced), int'(prev_v));
            end
            if (out_if.ready) begin
               if (exp_q.size() == 0) chk("output_without_input", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("pitch_out", int'(out_if.data), e.data);
                  chk("voiced", int'(voiced), int'(e.v));
               end
            end
         end else if (prev_stall) begin
            chk("stall_valid", int'(out_if.valid), 1);
         end
         prev_stall = out_if.valid && !out_if.ready;
         prev_valid = out_if.valid;
         prev_data  = out_if.data;
         prev_v     = voiced;
      end
   end

   task automatic send(input int p);
      exp_t e;
      int   od, n;
      bit   ov;
      m_step(p, od, ov);
      e.data = od; e.v = ov;
      exp_q.push_back(e);
      @(negedge clk);
      in_if.data  = 24'(p);
      in_if.valid = 1'b1;
      n = 0;
      while (!in_if.ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("input_accept_timeout", int'(n >= 200), 0);
      if (n >= 200) begin
         in_if.valid = 1'b0;
         void'(exp_q.pop_back());
         return;
      end
      @(posedge clk);
      #1;
      acc_q.push_back(cyc - 1);
      in_if.valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      int base, p, n, k;
      in_if.valid = 1'b0;
      in_if.data  = '0;
      reset = 1'b1;
      m_reset();
      repeat (3) @(negedge clk);
      chk("reset_valid", int'(out_if.valid), 0);
      chk("reset_data", int'(out_if.data), 0);
      chk("reset_voiced", int'(voiced), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", int'(in_if.ready), 1);

      repeat (3) send(32'h06E000);
      send(32'h070000);
      send(32'h0A0000);
      repeat (4) send(32'h000100);
      repeat (3) send(32'h00C800);
      send(32'h00C7FF);
      repeat (4) send(32'h000100);
      repeat (3) send(32'h1F4000);
      send(32'h1F4001);
      repeat (4) send(32'h000100);
      repeat (3) send(32'h06E000);
      send(32'h0DC000);
      send(32'h037000);
      send(32'h070000);
      drain();

      hold_bp = 1'b1;
      send(32'h06E000);
      repeat (10) @(negedge clk);
      chk("bp_in_ready", int'(in_if.ready), 0);
      chk("bp_out_valid", int'(out_if.valid), 1);
      hold_bp = 1'b0;
      drain();

      base = 32'h06E000;
      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 11);
         if (k == 0 && $urandom_range(0, 1) == 1) base = $urandom_range(32'h012000, 32'h180000);
         case (k)
            0:  p = $urandom_range(0, FMIN - 1);
            1:  p = $urandom_range(FMAX + 1, 32'hFFFFFF);
            2:  begin
                   n = $urandom_range(0, 3);
                   p = (n == 0) ? FMIN : (n == 1) ? FMIN - 1 : (n == 2) ? FMAX : FMAX + 1;
                end
            3:  p = ($urandom_range(0, 1) == 1) ? base * 2 : base / 2;
            4:  p = $urandom_range(FMIN, FMAX);
            default: p = base + (base * (int'($urandom_range(0, 16)) - 8)) / 100;
         endcase
         send(p);
      end
      drain();

      hold_bp = 1'b1;
      send(32'h06E000);
      n = 0;
      while (!out_if.valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("pre_reset_valid", int'(out_if.valid), 1);
      #3 reset = 1'b1;
      #1;
      chk("async_reset_valid", int'(out_if.valid), 0);
      chk("async_reset_data", int'(out_if.data), 0);
      chk("async_reset_voiced", int'(voiced), 0);
      exp_q.delete();
      acc_q.delete();
      m_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      hold_bp = 1'b0;
      @(negedge clk);
      chk("ready_after_mid_reset", int'(in_if.ready), 1);
      repeat (3) send(32'h06E000);
      send(32'h070000);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
